picobello_mcast_initiator: RTL and testbench
============================================

# picobello_mcast_initiator

Initiator-side multicast encoder for cluster tiles. It accepts a rectangular range of cluster mesh coordinates and splits the range into aligned power-of-two sub-blocks. For each sub-block it issues one write-address beat carrying a base address and an AXI user mask in the mask_x/mask_y format that the NoC multicast decoders consume. It then collects one B response per issued beat and returns a single merged response. It sits between a cluster DMA/control front end and the narrow AXI AW/B channels toward FlooNoC.

## Interface
Parameters:
- AddrWidth, 48, address and mask width; equals AxiCfgN.AddrWidth.
- IdWidth, 4, transaction ID width.
- LenX, 2, X-coordinate bit count (mask_x.len).
- LenY, 2, Y-coordinate bit count (mask_y.len).
- OffsetY, 18, log2 of the cluster tile address size (mask_y.offset).
- OffsetX, OffsetY+LenY, bit position of the X field (mask_x.offset).
- ClusterBase, 'h2000_0000, base of the cluster region; must be aligned to 2^(OffsetX+LenX).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- req_valid_i / req_ready_o  in/out  1  request handshake.
- req_x_lo_i, req_x_hi_i  in  LenX  inclusive X range.
- req_y_lo_i, req_y_hi_i  in  LenY  inclusive Y range.
- req_offset_i  in  OffsetY  byte offset inside each tile.
- req_id_i  in  IdWidth  transaction ID.
- aw_valid_o / aw_ready_i  out/in  1  AW handshake.
- aw_addr_o  out  AddrWidth  sub-block base address.
- aw_mask_o  out  AddrWidth  multicast user mask (1 = don't-care bit).
- aw_id_o  out  IdWidth  copy of the request ID.
- b_valid_i / b_ready_o  in/out  1  B handshake.
- b_resp_i  in  2  AXI response.
- rsp_valid_o / rsp_ready_i  out/in  1  merged response handshake.
- rsp_resp_o  out  2  merged response.
- rsp_id_o  out  IdWidth  request ID.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - req_ready_o=1.
  - On handshake, register the request and set the cursors cx=x_lo, cy=y_lo.
  - If x_lo>x_hi or y_lo>y_hi, go to RESP with SLVERR; no AW is issued.
  - Otherwise go to ISSUE.
- Chunk size per dimension: k = min(tz(cur), floor_log2(hi-cur+1)).
  - tz(0) is defined as Len.
  - The chunk covers cur..cur+2^k-1.
- aw_addr_o = ClusterBase | cx<<OffsetX | cy<<OffsetY | req_offset_i.
- aw_mask_o = ((2^kx-1)<<OffsetX) | ((2^ky-1)<<OffsetY).
- Iteration order: Y is the inner loop, X the outer loop.
  - After each AW handshake, advance cy by 2^ky.
  - When cy passes y_hi, reset cy to y_lo and advance cx by 2^kx.
  - When cx passes x_hi, go to DRAIN.
  - Cursor arithmetic is Len+1 bits wide so the comparison against hi+1 does not wrap.
- Counters:
  - issued_q counts AW handshakes; recvd_q counts B handshakes.
  - Width is clog2(4*LenX*LenY+1), which covers the worst-case sub-block count.
- B collection:
  - b_ready_o=1 in ISSUE and DRAIN; 0 otherwise.
  - Merged response is the worst seen: DECERR > SLVERR > OKAY. EXOKAY counts as OKAY.
  - A B handshake in the same cycle as the final AW is counted.
- DRAIN: when recvd_q==issued_q, go to RESP.
- RESP: rsp_valid_o=1. On rsp_ready_i, go to IDLE and clear the counters and merged response.

## Timing
- Reset values:
  - State IDLE.
  - All valid outputs 0; b_ready_o=0.
  - aw_addr_o, aw_mask_o, aw_id_o, rsp_resp_o and rsp_id_o are 0.
  - Counters are 0.
- Reset mid-operation drops all state at the next clock edge; any B responses still outstanding are lost.
- Request accepted in cycle 0: first aw_valid_o in cycle 1, from registered outputs.
- With aw_ready_i held high, one AW is issued per cycle.
- While aw_valid_o && !aw_ready_i, aw_addr_o, aw_mask_o and aw_id_o are held stable.
- rsp_valid_o rises the cycle after the last B handshake, or the cycle after the final AW if all Bs have already arrived.
- Invalid request: rsp_valid_o in cycle 1.
- rsp_valid_o stays high until rsp_ready_i. No new request is accepted before RESP completes (one transaction in flight).

## Structure
- mask_sel_t, mcast_user_t and the resp-merge function belong in picobello_pkg.
- LenX, LenY, OffsetY and OffsetX are derived in the top-level instance from sam_multicast of the cluster rules.
- One sub-module, picobello_mcast_chunk: combinational (cur, hi) -> k, instantiated once each for X and Y.

## Test plan
- Single cluster x=1, y=2, offset 0 -> one AW, addr 0x2018_0000, mask 0. B OKAY -> rsp OKAY.
- Full grid 0..3 × 0..3 -> one AW, addr 0x2000_0000, mask 0x3C_0000.
- x 1..3, y 0..1, in two subtests:
  - AW1: addr 0x2010_0000, mask 0x4_0000.
  - AW2: addr 0x2020_0000, mask 0x14_0000.
  - Subtest A: Bs OKAY then SLVERR -> rsp SLVERR.
  - Subtest B: Bs OKAY then DECERR -> rsp DECERR.
- x_lo=2, x_hi=1 -> no AW; rsp SLVERR in cycle 1.
- Full grid with aw_ready_i low for 3 cycles -> AW fields stable throughout; issued_q increments only on handshake.
- Reset asserted during DRAIN -> the next cycle shows IDLE, req_ready_o=1 and all valids 0.

Source files
------------

// File: rtl/picobello_pkg.sv
// Shared types, cluster multicast address rules and the B-response merge helper.
package picobello_pkg;

  localparam int unsigned AxiAddrWidth = 48;
  localparam logic [AxiAddrWidth-1:0] ClusterBaseAddr = 48'h2000_0000;

  // One coordinate field inside the address: where it starts and how many bits it has.
  typedef struct packed {
    int unsigned offset;
    int unsigned len;
  } mask_sel_t;

  typedef struct packed {
    mask_sel_t x;
    mask_sel_t y;
  } sam_multicast_t;

  // Cluster tiles are 2^18 bytes; Y occupies the bits just above, X above Y.
  localparam sam_multicast_t SamMulticast = '{
    x: '{offset: 20, len: 2},
    y: '{offset: 18, len: 2}
  };

  // AXI user payload consumed by the NoC multicast decoders (1 = don't-care bit).
  typedef struct packed {
    logic [AxiAddrWidth-1:0] mcastMask;
  } mcast_user_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } mcast_state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  function automatic logic [1:0] normResp(input logic [1:0] r);
    return (r == RespExOkay) ? RespOkay : r;
  endfunction

  // Once EXOKAY is folded into OKAY the encodings order by severity, so the worst is the max.
  function automatic logic [1:0] mergeResp(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] na;
    logic [1:0] nb;
    na = normResp(a);
    nb = normResp(b);
    return (na > nb) ? na : nb;
  endfunction

endpackage

// File: rtl/picobello_mcast_chunk.sv
// Size of the largest aligned power-of-two block starting at cur that still fits below hi.
module picobello_mcast_chunk #(
  parameter int unsigned Len    = 2,
  parameter int unsigned KWidth = $clog2(Len + 1)
) (
  input  logic [Len:0]      cur,
  input  logic [Len-1:0]    hi,
  output logic [KWidth-1:0] k
);

  logic [Len:0]      span;
  logic [KWidth-1:0] tz;
  logic [KWidth-1:0] flog;

  // k = min(trailing zeros of cur, floor(log2(hi - cur + 1))); a zero cursor is fully aligned.
  always_comb begin
    span = {1'b0, hi} - cur + (Len + 1)'(1);
    tz   = KWidth'(Len);
    for (int i = Len - 1; i >= 0; i--) begin
      if (cur[i]) tz = KWidth'(i);
    end
    flog = '0;
    for (int i = 0; i <= Len; i++) begin
      if (span[i]) flog = KWidth'(i);
    end
    k = (tz < flog) ? tz : flog;
  end

endmodule

// File: rtl/picobello_mcast_initiator.sv
// Splits a rectangular cluster range into aligned multicast AW beats and merges their B responses.
module picobello_mcast_initiator
  import picobello_pkg::*;
#(
  parameter int unsigned          AddrWidth   = AxiAddrWidth,
  parameter int unsigned          IdWidth     = 4,
  parameter int unsigned          LenX        = SamMulticast.x.len,
  parameter int unsigned          LenY        = SamMulticast.y.len,
  parameter int unsigned          OffsetY     = SamMulticast.y.offset,
  parameter int unsigned          OffsetX     = OffsetY + LenY,
  parameter logic [AddrWidth-1:0] ClusterBase = AddrWidth'(ClusterBaseAddr)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [LenX-1:0]      req_x_lo_i,
  input  logic [LenX-1:0]      req_x_hi_i,
  input  logic [LenY-1:0]      req_y_lo_i,
  input  logic [LenY-1:0]      req_y_hi_i,
  input  logic [OffsetY-1:0]   req_offset_i,
  input  logic [IdWidth-1:0]   req_id_i,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [AddrWidth-1:0] aw_addr_o,
  output logic [AddrWidth-1:0] aw_mask_o,
  output logic [IdWidth-1:0]   aw_id_o,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic [1:0]           b_resp_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [1:0]           rsp_resp_o,
  output logic [IdWidth-1:0]   rsp_id_o
);

  localparam int unsigned CntWidth = $clog2(4 * LenX * LenY + 1);
  localparam int unsigned KxWidth  = $clog2(LenX + 1);
  localparam int unsigned KyWidth  = $clog2(LenY + 1);

  mcast_state_e stateQ, stateD;

  logic [LenX-1:0]     xLoQ, xLoD, xHiQ, xHiD;
  logic [LenY-1:0]     yLoQ, yLoD, yHiQ, yHiD;
  logic [OffsetY-1:0]  offsetQ, offsetD;
  logic [IdWidth-1:0]  idQ, idD;
  logic [LenX:0]       cxQ, cxD, cxStep;
  logic [LenY:0]       cyQ, cyD, cyStep;
  logic [CntWidth-1:0] issuedQ, issuedD, recvdQ, recvdD;
  logic [1:0]          mergedQ, mergedD;
  logic [KxWidth-1:0]  kx;
  logic [KyWidth-1:0]  ky;
  logic                awFire, bFire;
  logic [LenX-1:0]     maskXBits;
  logic [LenY-1:0]     maskYBits;
  mcast_user_t         awUser;

  picobello_mcast_chunk #(.Len(LenX), .KWidth(KxWidth)) i_chunk_x (
    .cur (cxQ),
    .hi  (xHiQ),
    .k   (kx)
  );

  picobello_mcast_chunk #(.Len(LenY), .KWidth(KyWidth)) i_chunk_y (
    .cur (cyQ),
    .hi  (yHiQ),
    .k   (ky)
  );

  // Next-state, cursor walk (Y inner, X outer), counters and the Moore-decoded outputs.
  always_comb begin
    stateD  = stateQ;
    xLoD    = xLoQ;
    xHiD    = xHiQ;
    yLoD    = yLoQ;
    yHiD    = yHiQ;
    offsetD = offsetQ;
    idD     = idQ;
    cxD     = cxQ;
    cyD     = cyQ;

    req_ready_o = (stateQ == IDLE);
    aw_valid_o  = (stateQ == ISSUE);
    b_ready_o   = (stateQ == ISSUE) || (stateQ == DRAIN);
    rsp_valid_o = (stateQ == RESP);
    rsp_resp_o  = mergedQ;
    rsp_id_o    = idQ;

    maskXBits        = LenX'((1 << kx) - 1);
    maskYBits        = LenY'((1 << ky) - 1);
    awUser.mcastMask = AxiAddrWidth'((AddrWidth'(maskXBits) << OffsetX)
                                   | (AddrWidth'(maskYBits) << OffsetY));
    aw_addr_o = '0;
    aw_mask_o = '0;
    aw_id_o   = '0;
    if (stateQ == ISSUE) begin
      aw_addr_o = ClusterBase
                | (AddrWidth'(cxQ[LenX-1:0]) << OffsetX)
                | (AddrWidth'(cyQ[LenY-1:0]) << OffsetY)
                | AddrWidth'(offsetQ);
      aw_mask_o = AddrWidth'(awUser.mcastMask);
      aw_id_o   = idQ;
    end

    awFire  = (stateQ == ISSUE) && aw_ready_i;
    bFire   = b_valid_i && b_ready_o;
    issuedD = issuedQ + CntWidth'(awFire);
    recvdD  = recvdQ + CntWidth'(bFire);
    mergedD = bFire ? mergeResp(mergedQ, b_resp_i) : mergedQ;
    cxStep  = cxQ + ((LenX + 1)'(1) << kx);
    cyStep  = cyQ + ((LenY + 1)'(1) << ky);

    case (stateQ)
      IDLE: begin
        if (req_valid_i) begin
          xLoD    = req_x_lo_i;
          xHiD    = req_x_hi_i;
          yLoD    = req_y_lo_i;
          yHiD    = req_y_hi_i;
          offsetD = req_offset_i;
          idD     = req_id_i;
          cxD     = {1'b0, req_x_lo_i};
          cyD     = {1'b0, req_y_lo_i};
          if ((req_x_lo_i > req_x_hi_i) || (req_y_lo_i > req_y_hi_i)) begin
            mergedD = RespSlvErr;
            stateD  = RESP;
          end else begin
            stateD = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (awFire) begin
          if (cyStep > {1'b0, yHiQ}) begin
            cyD = {1'b0, yLoQ};
            cxD = cxStep;
            if (cxStep > {1'b0, xHiQ}) begin
              stateD = (recvdD == issuedD) ? RESP : DRAIN;
            end
          end else begin
            cyD = cyStep;
          end
        end
      end
      DRAIN: begin
        if (recvdD == issuedQ) stateD = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          stateD  = IDLE;
          issuedD = '0;
          recvdD  = '0;
          mergedD = RespOkay;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) stateQ <= IDLE;
    else         stateQ <= stateD;
  end

  // Request, cursor, counter and merged-response registers; reset drops any outstanding Bs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      xLoQ    <= '0;
      xHiQ    <= '0;
      yLoQ    <= '0;
      yHiQ    <= '0;
      offsetQ <= '0;
      idQ     <= '0;
      cxQ     <= '0;
      cyQ     <= '0;
      issuedQ <= '0;
      recvdQ  <= '0;
      mergedQ <= RespOkay;
    end else begin
      xLoQ    <= xLoD;
      xHiQ    <= xHiD;
      yLoQ    <= yLoD;
      yHiQ    <= yHiD;
      offsetQ <= offsetD;
      idQ     <= idD;
      cxQ     <= cxD;
      cyQ     <= cyD;
      issuedQ <= issuedD;
      recvdQ  <= recvdD;
      mergedQ <= mergedD;
    end
  end

endmodule

// File: tb/tb_picobello_mcast_initiator.sv
// Randomized bench for the multicast initiator, checked every cycle against a range-splitting model.
module tb_picobello_mcast_initiator;

  localparam int unsigned LenX    = 2;
  localparam int unsigned LenY    = 2;
  localparam int unsigned OffsetY = 18;
  localparam int unsigned OffsetX = 20;
  localparam logic [47:0] ClusterBase = 48'h2000_0000;
  localparam int Never = 32'h7fff_ffff;

  typedef struct packed {
    logic [47:0] addr;
    logic [47:0] mask;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i, req_ready_o;
  logic [1:0]  req_x_lo_i, req_x_hi_i, req_y_lo_i, req_y_hi_i;
  logic [17:0] req_offset_i;
  logic [3:0]  req_id_i;
  logic        aw_valid_o, aw_ready_i;
  logic [47:0] aw_addr_o, aw_mask_o;
  logic [3:0]  aw_id_o;
  logic        b_valid_i, b_ready_o;
  logic [1:0]  b_resp_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [1:0]  rsp_resp_o;
  logic [3:0]  rsp_id_o;

  int vectors = 0;
  int miscompares = 0;

  picobello_mcast_initiator dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_x_lo_i(req_x_lo_i), .req_x_hi_i(req_x_hi_i),
    .req_y_lo_i(req_y_lo_i), .req_y_hi_i(req_y_hi_i),
    .req_offset_i(req_offset_i), .req_id_i(req_id_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .aw_addr_o(aw_addr_o), .aw_mask_o(aw_mask_o), .aw_id_o(aw_id_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_resp_o(rsp_resp_o), .rsp_id_o(rsp_id_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Largest aligned power of two that starts at cur and stays within hi.
  function automatic int chunkSize(input int cur, input int hi, input int len);
    int s;
    int r;
    s = 1 << len;
    r = 1;
    while (s >= 1) begin
      if (((cur % s) == 0) && (cur + s - 1 <= hi)) begin
        r = s;
        s = 0;
      end else begin
        s = s / 2;
      end
    end
    return r;
  endfunction

  function automatic int modelCount(input int xlo, input int xhi, input int ylo, input int yhi);
    int n;
    int x;
    int y;
    n = 0;
    x = xlo;
    while (x <= xhi) begin
      y = ylo;
      while (y <= yhi) begin
        n++;
        y += chunkSize(y, yhi, LenY);
      end
      x += chunkSize(x, xhi, LenX);
    end
    return n;
  endfunction

  function automatic beat_t modelBeat(input int xlo, input int xhi, input int ylo, input int yhi,
                                      input logic [17:0] off, input int idx);
    beat_t b;
    int n, x, y, sx, sy;
    b = '0;
    n = 0;
    x = xlo;
    while (x <= xhi) begin
      sx = chunkSize(x, xhi, LenX);
      y = ylo;
      while (y <= yhi) begin
        sy = chunkSize(y, yhi, LenY);
        if (n == idx) begin
          b.addr = ClusterBase + (48'(x) << OffsetX) + (48'(y) << OffsetY) + 48'(off);
          b.mask = (48'(sx - 1) << OffsetX) + (48'(sy - 1) << OffsetY);
        end
        n++;
        y += sy;
      end
      x += sx;
    end
    return b;
  endfunction

  function automatic int severity(input logic [1:0] r);
    return (r == 2'b11) ? 2 : (r == 2'b10) ? 1 : 0;
  endfunction

  function automatic logic [1:0] sevCode(input int s);
    return (s == 2) ? 2'b11 : (s == 1) ? 2'b10 : 2'b00;
  endfunction

  // Shared between the model and the stimulus drivers.
  int         awMode = 1;
  bit         bHold = 0;
  int         bOwed = 0;
  bit         bTaken = 0;
  logic [1:0] bScript[$];

  // Model state.
  int    cycle = 0;
  bit    txnActive = 0;
  int    acceptCycle = 0;
  int    rspDue = Never;
  int    awCount = 0;
  int    bCount = 0;
  int    worstSev = 0;
  logic [3:0] expId = '0;
  beat_t expQ[$];

  // Compare process: checks every output every cycle, then advances the model by the coming edge's handshakes.
  always @(negedge clk) begin
    bit expAwValid;
    int n;
    cycle++;
    if (!rst_ni) begin
      txnActive = 0;
      expQ.delete();
      rspDue = Never;
      awCount = 0;
      bCount = 0;
      worstSev = 0;
      bOwed = 0;
      bTaken = 0;
    end else begin
      expAwValid = txnActive && (cycle > acceptCycle) && (expQ.size() > 0);
      checkOutput("aw_valid", aw_valid_o, expAwValid);
      if (aw_valid_o && expAwValid) begin
        checkOutput("aw_addr", aw_addr_o, expQ[0].addr);
        checkOutput("aw_mask", aw_mask_o, expQ[0].mask);
        checkOutput("aw_id", aw_id_o, expId);
      end
      checkOutput("b_ready", b_ready_o, txnActive && (cycle > acceptCycle) && (cycle < rspDue));
      checkOutput("rsp_valid", rsp_valid_o, txnActive && (cycle >= rspDue));
      checkOutput("req_ready", req_ready_o, !txnActive);
      if (txnActive) checkOutput("issued count", dut.issuedQ, awCount);
      if (txnActive && (cycle >= rspDue) && rsp_valid_o) begin
        checkOutput("rsp_resp", rsp_resp_o, sevCode(worstSev));
        checkOutput("rsp_id", rsp_id_o, expId);
      end

      if (txnActive && (cycle >= rspDue) && rsp_valid_o && rsp_ready_i) begin
        txnActive = 0;
        rspDue = Never;
      end else if (txnActive) begin
        if (aw_valid_o && aw_ready_i && expAwValid) begin
          void'(expQ.pop_front());
          awCount++;
          bOwed++;
        end
        if (b_valid_i && b_ready_o) begin
          bCount++;
          bOwed--;
          bTaken = 1;
          if (severity(b_resp_i) > worstSev) worstSev = severity(b_resp_i);
        end
        if ((rspDue == Never) && (cycle > acceptCycle) && (expQ.size() == 0) && (bCount == awCount))
          rspDue = cycle + 1;
      end else if (req_valid_i && req_ready_o) begin
        txnActive = 1;
        acceptCycle = cycle;
        expId = req_id_i;
        awCount = 0;
        bCount = 0;
        worstSev = 0;
        expQ.delete();
        n = modelCount(req_x_lo_i, req_x_hi_i, req_y_lo_i, req_y_hi_i);
        for (int i = 0; i < n; i++)
          expQ.push_back(modelBeat(req_x_lo_i, req_x_hi_i, req_y_lo_i, req_y_hi_i, req_offset_i, i));
        if ((req_x_lo_i > req_x_hi_i) || (req_y_lo_i > req_y_hi_i)) begin
          worstSev = 1;
          rspDue = cycle + 1;
        end
      end
    end
  end

  // AW ready driver: random, held high, or held low.
  initial begin
    aw_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      aw_ready_i = (awMode == 0) ? 1'($urandom_range(0, 1)) : (awMode == 1);
    end
  end

  // B driver: one response per issued AW, held until accepted, scripted or random codes.
  initial begin
    b_valid_i = 1'b0;
    b_resp_i = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_ni) begin
        b_valid_i = 1'b0;
        bTaken = 0;
      end else if (!(b_valid_i && !bTaken)) begin
        b_valid_i = 1'b0;
        bTaken = 0;
        if (!bHold && (bOwed > 0) && ($urandom_range(0, 2) != 0)) begin
          b_valid_i = 1'b1;
          b_resp_i = (bScript.size() > 0) ? bScript.pop_front() : 2'($urandom_range(0, 3));
        end
      end
    end
  end

  task automatic pulseReset();
    @(posedge clk);
    #1 rst_ni = 1'b0;
    @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic sendRequest(input int xlo, input int xhi, input int ylo, input int yhi,
                             input logic [17:0] off, input logic [3:0] id);
    bit ok;
    @(posedge clk);
    #1;
    req_x_lo_i = 2'(xlo);
    req_x_hi_i = 2'(xhi);
    req_y_lo_i = 2'(ylo);
    req_y_hi_i = 2'(yhi);
    req_offset_i = off;
    req_id_i = id;
    req_valid_i = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready_o) ok = 1;
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_x_lo_i = 2'($urandom);
    req_offset_i = 18'($urandom);
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL req handshake: got no req_ready, expected one within 50 cycles");
    end
  endtask

  task automatic awaitResponse(input int expResp);
    bit got;
    int d;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid_o) got = 1;
    end
    if (!got) begin
      miscompares++;
      $display("[TB] FAIL rsp timeout: got no rsp_valid, expected one within 300 cycles");
      pulseReset();
    end else begin
      if (expResp >= 0) checkOutput("rsp_resp literal", rsp_resp_o, 64'(expResp));
      d = $urandom_range(0, 3);
      repeat (d) @(posedge clk);
      @(posedge clk);
      #1 rsp_ready_i = 1'b1;
      @(posedge clk);
      #1 rsp_ready_i = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int xlo, input int xhi, input int ylo, input int yhi,
                               input logic [17:0] off, input logic [3:0] id, input int expResp);
    sendRequest(xlo, xhi, ylo, yhi, off, id);
    awaitResponse(expResp);
  endtask

  initial begin
    beat_t b;
    req_valid_i = 1'b0;
    req_x_lo_i = '0;
    req_x_hi_i = '0;
    req_y_lo_i = '0;
    req_y_hi_i = '0;
    req_offset_i = '0;
    req_id_i = '0;
    rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    @(negedge clk);
    checkOutput("reset aw_addr", aw_addr_o, 0);
    checkOutput("reset aw_mask", aw_mask_o, 0);
    checkOutput("reset aw_id", aw_id_o, 0);
    checkOutput("reset rsp_resp", rsp_resp_o, 0);
    checkOutput("reset rsp_id", rsp_id_o, 0);
    checkOutput("reset req_ready", req_ready_o, 1);

    checkOutput("model count 1..3x0..1", modelCount(1, 3, 0, 1), 2);
    b = modelBeat(1, 3, 0, 1, 18'h0, 0);
    checkOutput("model aw1 addr", b.addr, 48'h2010_0000);
    checkOutput("model aw1 mask", b.mask, 48'h4_0000);
    b = modelBeat(1, 3, 0, 1, 18'h0, 1);
    checkOutput("model aw2 addr", b.addr, 48'h2020_0000);
    checkOutput("model aw2 mask", b.mask, 48'h14_0000);
    b = modelBeat(0, 3, 0, 3, 18'h0, 0);
    checkOutput("model grid count", modelCount(0, 3, 0, 3), 1);
    checkOutput("model grid addr", b.addr, 48'h2000_0000);
    checkOutput("model grid mask", b.mask, 48'h3C_0000);
    b = modelBeat(1, 1, 2, 2, 18'h0, 0);
    checkOutput("model single addr", b.addr, 48'h2018_0000);
    checkOutput("model single mask", b.mask, 48'h0);
    checkOutput("model invalid count", modelCount(2, 1, 0, 3), 0);

    awMode = 1;
    bScript = '{2'b00};
    applyStimulus(1, 1, 2, 2, 18'h0, 4'h3, 0);
    bScript = '{2'b01};
    applyStimulus(0, 3, 0, 3, 18'h1234, 4'h5, 0);
    bScript = '{2'b00, 2'b10};
    applyStimulus(1, 3, 0, 1, 18'h0, 4'h9, 2);
    bScript = '{2'b00, 2'b11};
    applyStimulus(1, 3, 0, 1, 18'h40, 4'hC, 3);
    applyStimulus(2, 1, 0, 3, 18'h0, 4'hA, 2);

    awMode = 2;
    bScript = '{2'b00};
    sendRequest(0, 3, 0, 3, 18'h0, 4'h6);
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall aw_valid", aw_valid_o, 1);
      checkOutput("stall aw_addr", aw_addr_o, 48'h2000_0000);
      checkOutput("stall aw_mask", aw_mask_o, 48'h3C_0000);
      checkOutput("stall issued", dut.issuedQ, 0);
    end
    awMode = 1;
    awaitResponse(0);

    bHold = 1;
    sendRequest(0, 3, 0, 3, 18'h0, 4'h7);
    repeat (3) @(negedge clk);
    checkOutput("drain b_ready", b_ready_o, 1);
    checkOutput("drain rsp_valid", rsp_valid_o, 0);
    pulseReset();
    @(negedge clk);
    checkOutput("post-reset req_ready", req_ready_o, 1);
    checkOutput("post-reset aw_valid", aw_valid_o, 0);
    checkOutput("post-reset b_ready", b_ready_o, 0);
    checkOutput("post-reset rsp_valid", rsp_valid_o, 0);
    bHold = 0;

    bScript.delete();
    for (int t = 0; t < 150; t++) begin
      awMode = $urandom_range(0, 1);
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 18'($urandom), 4'($urandom), -1);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
